// File: rtl/password_controller.sv
// Keypad password controller: filters single-key presses, collects PW_LEN digits,
// checks them on Enter, and grants access or counts failures toward a timed lockout.
module password_controller #(
  parameter int                  PW_LEN      = 4,
  parameter logic [PW_LEN*4-1:0] PASSWORD    = 16'h1234,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  OPEN_CYCLES = 8,
  parameter int                  LOCK_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] buttons,
  input  logic [3:0]  enc_digit,
  output logic        unlock,
  output logic        err,
  output logic        locked,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  state
);

  localparam int EW = PW_LEN * 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    FAIL     = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  state_t cur, nxt;

  logic [15:0]   buttons_q;
  logic [EW-1:0] entry;
  logic [3:0]    fail_cnt;
  logic [31:0]   timer;

  logic press, digit_ev, enter_ev, clear_ev;
  logic pass, lock_hit, timer_done;
  logic [3:0] fail_next;
  logic unlock_d, err_d, locked_d;

  // An event needs a fully released keypad on the previous cycle and one legal key now.
  assign press    = (buttons_q == 16'h0000) && (buttons[15:12] == 4'h0) && $onehot(buttons[11:0]);
  assign digit_ev = press && (|buttons[9:0]);
  assign enter_ev = press && buttons[10];
  assign clear_ev = press && buttons[11];

  assign pass       = (digit_cnt == 3'(PW_LEN)) && (entry == PASSWORD);
  assign fail_next  = fail_cnt + 4'd1;
  assign lock_hit   = (fail_next == 4'(MAX_TRIES));
  assign timer_done = (timer == 32'd0);

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     if (digit_ev) nxt = ENTRY;
      ENTRY: begin
        if (clear_ev)      nxt = IDLE;
        else if (enter_ev) nxt = CHECK;
      end
      CHECK:    nxt = pass ? UNLOCKED : (lock_hit ? LOCKOUT : FAIL);
      UNLOCKED: if (timer_done) nxt = IDLE;
      FAIL:     nxt = IDLE;
      LOCKOUT:  if (timer_done) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Output values are decoded from the next state so the registered flags track state exactly.
  always_comb begin
    unlock_d = (nxt == UNLOCKED);
    err_d    = (nxt == FAIL);
    locked_d = (nxt == LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons_q <= 16'hFFFF;
      entry     <= '0;
      digit_cnt <= 3'd0;
      fail_cnt  <= 4'd0;
      timer     <= 32'd0;
      unlock    <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      buttons_q <= buttons;
      unlock    <= unlock_d;
      err       <= err_d;
      locked    <= locked_d;

      case (cur)
        IDLE: begin
          if (digit_ev) begin
            entry     <= EW'(enc_digit);
            digit_cnt <= 3'd1;
          end
        end
        ENTRY: begin
          if (clear_ev) begin
            entry     <= '0;
            digit_cnt <= 3'd0;
          end else if (digit_ev && (digit_cnt < 3'(PW_LEN))) begin
            entry     <= (entry << 4) | EW'(enc_digit);
            digit_cnt <= digit_cnt + 3'd1;
          end
        end
        CHECK: begin
          entry     <= '0;
          digit_cnt <= 3'd0;
          fail_cnt  <= pass ? 4'd0 : fail_next;
        end
        UNLOCKED: begin
          if (!timer_done) timer <= timer - 32'd1;
        end
        LOCKOUT: begin
          if (!timer_done) timer <= timer - 32'd1;
          else             fail_cnt <= 4'd0;
        end
        default: ;
      endcase

      // The shared timer is loaded on the CHECK exit edge so each timed state lasts its full count.
      if (cur == CHECK && nxt == UNLOCKED) timer <= 32'(OPEN_CYCLES - 1);
      if (cur == CHECK && nxt == LOCKOUT)  timer <= 32'(LOCK_CYCLES - 1);
    end
  end

endmodule

// File: tb/tb_password_controller.sv
// Self-checking bench for password_controller: expected digit counts go through a
// scoreboard queue; each scenario task compares outputs inline.
module tb_password_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] buttons;
  logic [3:0]  enc_digit;
  logic        unlock, err, locked;
  logic [2:0]  digit_cnt;
  logic [2:0]  state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2,
                         S_UNLOCKED = 3'd3, S_FAIL = 3'd4, S_LOCKOUT = 3'd5;

  password_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buttons   (buttons),
    .enc_digit (enc_digit),
    .unlock    (unlock),
    .err       (err),
    .locked    (locked),
    .digit_cnt (digit_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One press-and-release; the event is sampled on the rising edge between the two negedges.
  task automatic key(input int idx, input logic [3:0] dig);
    @(negedge clk);
    buttons   = 16'(1 << idx);
    enc_digit = dig;
    @(negedge clk);
    buttons   = 16'h0000;
    enc_digit = 4'h0;
  endtask

  task automatic key_cnt(input int idx, input logic [3:0] dig, input logic [2:0] exp_cnt, input string name);
    exp_q.push_back(exp_cnt);
    key(idx, dig);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (digit_cnt !== exp_v)
      $display("[TB] FAIL %s: digit_cnt=%0d expected %0d", name, digit_cnt, exp_v);
    else pass_cnt++;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state !== S_IDLE && n < 60) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (state !== S_IDLE) $display("[TB] FAIL %s: state=%0d expected %0d (timeout)", name, state, S_IDLE);
    else pass_cnt++;
  endtask

  // Wrong entry of a single digit followed by Enter; returns with state just past CHECK.
  task automatic wrong_one(input logic [2:0] exp_state, input string name);
    key_cnt(9, 4'd9, 3'd1, {name, "_cnt"});
    key(10, 4'h0);
    @(negedge clk);
    total_cnt++;
    if (state !== exp_state) $display("[TB] FAIL %s: state=%0d expected %0d", name, state, exp_state);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({unlock, err, locked, digit_cnt, state} !== 9'b0)
      $display("[TB] FAIL reset_outputs: got u=%b e=%b l=%b cnt=%0d st=%0d expected all 0",
               unlock, err, locked, digit_cnt, state);
    else pass_cnt++;
  endtask

  task automatic test_correct();
    int cnt;
    for (int i = 1; i <= 4; i++) key_cnt(i, 4'(i), 3'(i), "correct_digit");
    key(10, 4'h0);
    total_cnt++;
    if (state !== S_CHECK) $display("[TB] FAIL correct_check: state=%0d expected %0d", state, S_CHECK);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== S_UNLOCKED || unlock !== 1'b1)
      $display("[TB] FAIL correct_unlocked: state=%0d unlock=%b expected %0d/1", state, unlock, S_UNLOCKED);
    else pass_cnt++;
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (unlock) cnt++;
    end
    total_cnt++;
    if (cnt !== 8) $display("[TB] FAIL correct_unlock_len: cycles=%0d expected 8", cnt);
    else pass_cnt++;
    total_cnt++;
    if (state !== S_IDLE || digit_cnt !== 3'd0)
      $display("[TB] FAIL correct_end: state=%0d cnt=%0d expected 0/0", state, digit_cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrong();
    int cnt;
    logic [3:0] d [4];
    d = '{4'd1, 4'd2, 4'd3, 4'd5};
    for (int i = 0; i < 4; i++) key_cnt(int'(d[i]), d[i], 3'(i + 1), "wrong_digit");
    key(10, 4'h0);
    @(negedge clk);
    total_cnt++;
    if (state !== S_FAIL || err !== 1'b1)
      $display("[TB] FAIL wrong_err: state=%0d err=%b expected %0d/1", state, err, S_FAIL);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== S_IDLE || err !== 1'b0)
      $display("[TB] FAIL wrong_err_end: state=%0d err=%b expected 0/0", state, err);
    else pass_cnt++;

    key_cnt(1, 4'd1, 3'd1, "short_digit");
    key_cnt(2, 4'd2, 3'd2, "short_digit");
    key(10, 4'h0);
    @(negedge clk);
    total_cnt++;
    if (state !== S_FAIL || err !== 1'b1)
      $display("[TB] FAIL short_err: state=%0d err=%b expected %0d/1", state, err, S_FAIL);
    else pass_cnt++;
    @(negedge clk);

    wrong_one(S_LOCKOUT, "third_fail_lockout");
    cnt = locked ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (locked) cnt++;
      if (err) cnt = cnt + 100;
    end
    total_cnt++;
    if (cnt !== 20) $display("[TB] FAIL lockout_len: cycles=%0d expected 20", cnt);
    else pass_cnt++;
    total_cnt++;
    if (state !== S_IDLE) $display("[TB] FAIL lockout_end: state=%0d expected 0", state);
    else pass_cnt++;
    // A cleared fail counter means the next wrong try is an ordinary failure.
    wrong_one(S_FAIL, "post_lockout_fail");
    @(negedge clk);
  endtask

  task automatic test_overflow_clear();
    logic [3:0] d [5];
    logic [2:0] e [5];
    d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    e = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int i = 0; i < 5; i++) key_cnt(int'(d[i]), d[i], e[i], "overflow_digit");
    key(10, 4'h0);
    @(negedge clk);
    total_cnt++;
    if (unlock !== 1'b1) $display("[TB] FAIL overflow_unlock: unlock=%b expected 1", unlock);
    else pass_cnt++;
    wait_idle("overflow_idle");
    key_cnt(1, 4'd1, 3'd1, "clear_digit");
    key_cnt(2, 4'd2, 3'd2, "clear_digit");
    key_cnt(11, 4'h0, 3'd0, "clear_cnt");
    total_cnt++;
    if (state !== S_IDLE) $display("[TB] FAIL clear_state: state=%0d expected 0", state);
    else pass_cnt++;
  endtask

  task automatic test_filter();
    @(negedge clk);
    buttons = 16'h0008; enc_digit = 4'd3;
    repeat (10) @(negedge clk);
    buttons = 16'h0000; enc_digit = 4'h0;
    @(negedge clk);
    total_cnt++;
    if (digit_cnt !== 3'd1) $display("[TB] FAIL held_key: digit_cnt=%0d expected 1", digit_cnt);
    else pass_cnt++;
    buttons = 16'h0003; enc_digit = 4'd1;
    repeat (2) @(negedge clk);
    buttons = 16'h0000;
    @(negedge clk);
    buttons = 16'h1000;
    repeat (2) @(negedge clk);
    buttons = 16'h0000; enc_digit = 4'h0;
    @(negedge clk);
    total_cnt++;
    if (digit_cnt !== 3'd1 || state !== S_ENTRY)
      $display("[TB] FAIL illegal_keys: cnt=%0d state=%0d expected 1/%0d", digit_cnt, state, S_ENTRY);
    else pass_cnt++;
    // Rolling from one key to another without a release must not register the second key.
    buttons = 16'h0010; enc_digit = 4'd4;
    @(negedge clk);
    buttons = 16'h0020; enc_digit = 4'd5;
    @(negedge clk);
    buttons = 16'h0000; enc_digit = 4'h0;
    @(negedge clk);
    total_cnt++;
    if (digit_cnt !== 3'd2) $display("[TB] FAIL rollover: digit_cnt=%0d expected 2", digit_cnt);
    else pass_cnt++;
    key_cnt(11, 4'h0, 3'd0, "filter_clear");

    for (int i = 1; i <= 4; i++) key_cnt(i, 4'(i), 3'(i), "unlock_digit");
    key(10, 4'h0);
    @(negedge clk);
    key(5, 4'd5);
    total_cnt++;
    if (state !== S_UNLOCKED || digit_cnt !== 3'd0)
      $display("[TB] FAIL press_in_unlocked: state=%0d cnt=%0d expected %0d/0", state, digit_cnt, S_UNLOCKED);
    else pass_cnt++;
    wait_idle("unlock_idle");
    total_cnt++;
    if (digit_cnt !== 3'd0) $display("[TB] FAIL unlock_ignored: digit_cnt=%0d expected 0", digit_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_lockout();
    wrong_one(S_FAIL, "rst_fail1");
    @(negedge clk);
    wrong_one(S_FAIL, "rst_fail2");
    @(negedge clk);
    wrong_one(S_LOCKOUT, "rst_fail3");
    repeat (5) @(negedge clk);
    buttons = 16'h0020; enc_digit = 4'd5;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({unlock, err, locked, digit_cnt, state} !== 9'b0)
      $display("[TB] FAIL reset_mid_lockout: u=%b e=%b l=%b cnt=%0d st=%0d expected all 0",
               unlock, err, locked, digit_cnt, state);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({locked, digit_cnt, state} !== 7'b0)
      $display("[TB] FAIL held_through_reset: l=%b cnt=%0d st=%0d expected 0", locked, digit_cnt, state);
    else pass_cnt++;
    buttons = 16'h0000; enc_digit = 4'h0;
    @(negedge clk);
    key_cnt(5, 4'd5, 3'd1, "repress_after_reset");
    key_cnt(11, 4'h0, 3'd0, "final_clear");
  endtask

  initial begin
    rst_n = 1'b0; buttons = 16'h0000; enc_digit = 4'h0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_correct();
    test_wrong();
    test_overflow_clear();
    test_filter();
    test_reset_lockout();
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
